food_map_ctrl: RTL and testbench

- Owns the per-cell food map for the maze: 2-bit food type per cell on a square grid of 2^CELL_BITS × 2^CELL_BITS cells.
- Shares the map between three requesters:
  - the pixel renderer, which reads a cell type and feeds it to the food sprite layout;
  - the player/game logic, which eats food;
  - an internal respawn scheduler.
- Also sequences the initial fill after reset and tracks the live food count.

---
 rtl/food_map_ctrl_pkg.sv | 43 ++++
 rtl/food_map_ctrl_lfsr16.sv | 29 ++
 rtl/food_map_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_food_map_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/food_map_ctrl_pkg.sv
// food_map_ctrl_pkg: shared constants for the maze food map controller.
// Holds the food type codes, the FSM state encoding, the per-type score
// values and a helper that maps a food type to its score.
`timescale 1ns/1ps
package food_map_ctrl_pkg;

   localparam int unsigned LFSR_W  = 16;
   localparam int unsigned FTYPE_W = 2;
   localparam int unsigned SCORE_W = 16;

   // Food type codes stored per cell
   localparam logic [FTYPE_W-1:0] FOOD_NONE   = 2'd0;
   localparam logic [FTYPE_W-1:0] FOOD_SMALL  = 2'd1;
   localparam logic [FTYPE_W-1:0] FOOD_MEDIUM = 2'd2;
   localparam logic [FTYPE_W-1:0] FOOD_BIG    = 2'd3;

   // Points awarded per consumed food type
   localparam logic [SCORE_W-1:0] SCORE_NONE   = 16'd0;
   localparam logic [SCORE_W-1:0] SCORE_SMALL  = 16'd1;
   localparam logic [SCORE_W-1:0] SCORE_MEDIUM = 16'd5;
   localparam logic [SCORE_W-1:0] SCORE_BIG    = 16'd20;

   // Write-port arbitration states
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_EAT  = 2'd2,
      ST_PICK = 2'd3
   } state_t;

   // Score value for one consumed cell
   function automatic logic [SCORE_W-1:0] food_score(input logic [FTYPE_W-1:0] ftype);
      logic [SCORE_W-1:0] pts;
      case (ftype)
         FOOD_SMALL:  pts = SCORE_SMALL;
         FOOD_MEDIUM: pts = SCORE_MEDIUM;
         FOOD_BIG:    pts = SCORE_BIG;
         default:     pts = SCORE_NONE;
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/food_map_ctrl_lfsr16.sv
// food_lfsr16: seedable 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Ports: clk, rst_n (async active-low, loads SEED), en (advance when high),
//        value (current LFSR state).
`timescale 1ns/1ps
module food_lfsr16
   import food_map_ctrl_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [LFSR_W-1:0] value
);

   logic fb;

   // Tap positions 16,14,13,11 counted from 1 map to bits 15,13,12,10
   always_comb fb = value[15] ^ value[13] ^ value[12] ^ value[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= SEED;
      end else if (en) begin
         value <= {value[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/food_map_ctrl.sv
// food_map_ctrl: owns the per-cell food map of the maze.
// A dedicated render read port returns map[rd_y][rd_x] one cycle later and
// never stalls. A single write port is arbitrated by one FSM between the
// post-reset fill (INIT), player eats (EAT) and the random respawn (PICK).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   frame_tick         one-cycle pulse per video frame (respawn timebase)
//   rd_x, rd_y         render cell coordinate -> rd_ftype (registered)
//   eat_req/x/y        eat request, held until eat_ack
//   eat_ack, eat_ftype completion pulse and type consumed (0 = empty cell)
//   food_count         number of non-empty cells
//   init_done          initial fill complete
//   score              accumulated score
// Optional feature macro: FOOD_SCORE_EN (score accumulation; otherwise
// score is tied to zero).
`timescale 1ns/1ps
module food_map_ctrl
   import food_map_ctrl_pkg::*;
#(
   parameter int unsigned       CELL_BITS     = 4,
   parameter int unsigned       RESPAWN_TICKS = 60,
   parameter int unsigned       MAX_TRIES     = 4,
   parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_tick,
   input  logic [CELL_BITS-1:0]   rd_x,
   input  logic [CELL_BITS-1:0]   rd_y,
   output logic [FTYPE_W-1:0]     rd_ftype,
   input  logic                   eat_req,
   input  logic [CELL_BITS-1:0]   eat_x,
   input  logic [CELL_BITS-1:0]   eat_y,
   output logic                   eat_ack,
   output logic [FTYPE_W-1:0]     eat_ftype,
   output logic [2*CELL_BITS:0]   food_count,
   output logic                   init_done,
   output logic [SCORE_W-1:0]     score
);

   localparam int unsigned ADDR_W = 2 * CELL_BITS;
   localparam int unsigned CELLS  = 1 << ADDR_W;
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned TMR_W  = $clog2(RESPAWN_TICKS + 1);
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

   state_t              state, state_nx;
   logic [FTYPE_W-1:0]  map [CELLS];

   logic [ADDR_W-1:0]   init_idx, init_idx_nx;
   logic [TRY_W-1:0]    tries, tries_nx;
   logic [TMR_W-1:0]    timer, timer_nx;
   logic [CNT_W-1:0]    food_count_nx;
   logic                init_done_nx;
   logic                eat_ack_nx;
   logic [FTYPE_W-1:0]  eat_ftype_nx;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [FTYPE_W-1:0]  wr_data;

   logic [LFSR_W-1:0]   lfsr;
   logic [ADDR_W-1:0]   eat_addr, pick_addr;
   logic [FTYPE_W-1:0]  eat_old, pick_old, pick_type;
   logic                timer_exp, map_full;
   logic                unused_lfsr;

   // Free-running cell picker
   food_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .value (lfsr)
   );

   assign unused_lfsr = ^lfsr;

   // Read-side decode for the eat and respawn candidates
   always_comb begin
      eat_addr  = {eat_y, eat_x};
      pick_addr = lfsr[ADDR_W-1:0];
      eat_old   = map[eat_addr];
      pick_old  = map[pick_addr];
      pick_type = (lfsr[LFSR_W-1 -: FTYPE_W] == FOOD_NONE) ? FOOD_SMALL
                                                          : lfsr[LFSR_W-1 -: FTYPE_W];
      timer_exp = (timer == TMR_W'(RESPAWN_TICKS));
      map_full  = (food_count == CNT_W'(CELLS));
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         init_idx   <= '0;
         tries      <= '0;
         timer      <= '0;
         food_count <= '0;
         init_done  <= 1'b0;
         eat_ack    <= 1'b0;
         eat_ftype  <= FOOD_NONE;
      end else begin
         state      <= state_nx;
         init_idx   <= init_idx_nx;
         tries      <= tries_nx;
         timer      <= timer_nx;
         food_count <= food_count_nx;
         init_done  <= init_done_nx;
         eat_ack    <= eat_ack_nx;
         eat_ftype  <= eat_ftype_nx;
      end
   end

   // Next state, write-port arbitration and counter updates
   always_comb begin
      state_nx      = state;
      init_idx_nx   = init_idx;
      tries_nx      = tries;
      timer_nx      = timer;
      food_count_nx = food_count;
      init_done_nx  = init_done;
      eat_ack_nx    = 1'b0;
      eat_ftype_nx  = eat_ftype;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = FOOD_NONE;

      // Respawn timer saturates; clears below take precedence
      if (state != ST_INIT && frame_tick && !timer_exp) begin
         timer_nx = timer + TMR_W'(1);
      end

      case (state)
         ST_INIT: begin
            wr_en       = 1'b1;
            wr_addr     = init_idx;
            wr_data     = FOOD_SMALL;
            init_idx_nx = init_idx + ADDR_W'(1);
            if (init_idx == ADDR_W'(CELLS - 1)) begin
               food_count_nx = CNT_W'(CELLS);
               init_done_nx  = 1'b1;
               state_nx      = ST_IDLE;
            end
         end

         ST_IDLE: begin
            // eat_ack high here means the requester may still hold the
            // request it was just acked for
            if (eat_req && !eat_ack) begin
               state_nx = ST_EAT;
            end else if (timer_exp) begin
               if (map_full) begin
                  timer_nx = '0;
               end else begin
                  tries_nx = '0;
                  state_nx = ST_PICK;
               end
            end
         end

         ST_EAT: begin
            wr_en        = 1'b1;
            wr_addr      = eat_addr;
            wr_data      = FOOD_NONE;
            eat_ack_nx   = 1'b1;
            eat_ftype_nx = eat_old;
            if (eat_old != FOOD_NONE) begin
               food_count_nx = food_count - CNT_W'(1);
            end
            state_nx = ST_IDLE;
         end

         ST_PICK: begin
            if (pick_old == FOOD_NONE) begin
               wr_en         = 1'b1;
               wr_addr       = pick_addr;
               wr_data       = pick_type;
               food_count_nx = food_count + CNT_W'(1);
               timer_nx      = '0;
               state_nx      = ST_IDLE;
            end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
               timer_nx = '0;
               state_nx = ST_IDLE;
            end else begin
               tries_nx = tries + TRY_W'(1);
            end
         end

         default: state_nx = ST_INIT;
      endcase
   end

   // Map storage: contents are undefined until INIT has swept every cell
   always_ff @(posedge clk) begin
      if (wr_en) begin
         map[wr_addr] <= wr_data;
      end
   end

   // Render port: pre-write value when a write hits the same cell
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ftype <= FOOD_NONE;
      end else begin
         rd_ftype <= map[{rd_y, rd_x}];
      end
   end

`ifdef FOOD_SCORE_EN
   logic [SCORE_W:0] score_sum;

   always_comb score_sum = (SCORE_W + 1)'(score) + (SCORE_W + 1)'(food_score(eat_old));

   // Saturating accumulate, committed together with eat_ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score <= '0;
      end else if (state == ST_EAT) begin
         score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      end
   end
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_food_map_ctrl.sv
// tb_food_map_ctrl: directed self-checking bench for food_map_ctrl.
// Keeps a shadow map, live-count and score model plus an independent LFSR
// model so respawn picks can be predicted cycle-exactly.
`timescale 1ns/1ps
module tb_food_map_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [3:0] rd_x = '0, rd_y = '0;
   logic [1:0] rd_ftype;
   logic       eat_req = 1'b0;
   logic [3:0] eat_x = '0, eat_y = '0;
   logic       eat_ack;
   logic [1:0] eat_ftype;
   logic [8:0] food_count;
   logic       init_done;
   logic [15:0] score;

   int errors = 0;
   int checks = 0;

   logic [1:0]  mm [256];
   int          cnt_m;
   int          score_m;
   logic [15:0] lm;
   int unsigned cyc = 0;

   food_map_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_ftype   (rd_ftype),
      .eat_req    (eat_req),
      .eat_x      (eat_x),
      .eat_y      (eat_y),
      .eat_ack    (eat_ack),
      .eat_ftype  (eat_ftype),
      .food_count (food_count),
      .init_done  (init_done),
      .score      (score)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lm <= 16'hACE1;
      else        lm <= lstep(lm);
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sval(input logic [1:0] t);
`ifdef FOOD_SCORE_EN
      case (t)
         2'd1: return 1;
         2'd2: return 5;
         2'd3: return 20;
         default: return 0;
      endcase
`else
      return 0 * int'(t);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         step(1);
         frame_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic wait_cyc(input int unsigned target);
      while (cyc < target) step(1);
   endtask

   task automatic model_fill();
      for (int i = 0; i < 256; i++) mm[i] = 2'd1;
      cnt_m   = 256;
      score_m = 0;
   endtask

   // Eat one cell and check latency, data, count, score and single ack
   task automatic do_eat(input logic [7:0] a, input int exp_lat);
      logic [1:0] exp;
      int n;
      exp     = mm[a];
      eat_x   = a[3:0];
      eat_y   = a[7:4];
      rd_x    = a[3:0];
      rd_y    = a[7:4];
      eat_req = 1'b1;
      n = 0;
      while (!eat_ack && n < 20) begin
         step(1);
         n++;
      end
      check("eat_latency", n, exp_lat);
      check("eat_ftype", eat_ftype, exp);
      check("rd_same_cycle_old", rd_ftype, exp);
      if (exp != 2'd0) cnt_m--;
      score_m += sval(exp);
      if (score_m > 65535) score_m = 65535;
      mm[a] = 2'd0;
      check("eat_food_count", food_count, cnt_m);
      check("eat_score", score, score_m);
      step(1);
      eat_req = 1'b0;
      check("eat_single_ack", eat_ack, 0);
      check("rd_after_eat", rd_ftype, 0);
      step(1);
      check("eat_no_second_ack", eat_ack, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_ftype", rd_ftype, 0);
      check("rst_eat_ack", eat_ack, 0);
      check("rst_eat_ftype", eat_ftype, 0);
      check("rst_food_count", food_count, 0);
      check("rst_init_done", init_done, 0);
      check("rst_score", score, 0);
   endtask

   // Release reset and time the fill; also watch for stray acks
   task automatic run_init();
      int n;
      int acks;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      acks = 0;
      while (!init_done && n < 300) begin
         step(1);
         n++;
         if (eat_ack) acks++;
      end
      check("init_done_cycle", n + 1, 257);
      check("init_food_count", food_count, 256);
      check("init_no_ack", acks, 0);
      model_fill();
   endtask

   function automatic bit picks_blocked(input logic [15:0] v);
      logic [15:0] w;
      w = v;
      for (int k = 0; k < 4; k++) begin
         if (mm[w[7:0]] == 2'd0) return 1'b0;
         w = lstep(w);
      end
      return 1'b1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] v;
      logic [7:0]  x;
      logic [1:0]  cand;
      int unsigned e;
      int          j;

      // Reset values and initial fill
      rd_x = 4'd3;
      rd_y = 4'd5;
      step(2);
      check_reset_outputs();
      run_init();
      step(1);
      check("init_rd_3_5", rd_ftype, 1);

      // Eat a full cell, then the same now-empty cell
      do_eat(8'h22, 2);
      do_eat(8'h22, 2);

      // Respawn into a cell emptied ahead of a predicted pick
      ticks(59);
      e = cyc + 10;
      v = lm;
      repeat (11) v = lstep(v);
      x    = v[7:0];
      cand = (v[15:14] == 2'd0) ? 2'd1 : v[15:14];
      if (mm[x] != 2'd0) do_eat(x, 2);
      wait_cyc(e - 1);
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
      check("pick_not_early", food_count, cnt_m);
      step(1);
      cnt_m++;
      mm[x] = cand;
      check("pick_food_count", food_count, cnt_m);
      rd_x = x[3:0];
      rd_y = x[7:4];
      step(1);
      check("pick_cell_type", rd_ftype, cand);

      // Four occupied picks stall a concurrent eat by exactly four cycles
      ticks(59);
      j = 10;
      v = lm;
      repeat (11) v = lstep(v);
      while (!picks_blocked(v) && j < 200) begin
         v = lstep(v);
         j++;
      end
      e = cyc + j;
      wait_cyc(e - 1);
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
      do_eat(8'h10, 6);
      do_eat(8'h11, 2);

      // Reset in the EAT cycle drops the ack and restarts the fill
      eat_x   = 4'd3;
      eat_y   = 4'd3;
      eat_req = 1'b1;
      step(1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      eat_req = 1'b0;
      step(2);
      check("rst_hold_no_ack", eat_ack, 0);
      run_init();

      // Full map: expired timer skips PICK and clears
      ticks(60);
      step(3);
      check("full_food_count", food_count, 256);
      do_eat(8'h01, 2);
      do_eat(8'h02, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
